// File: rtl/spi_seq_pkg.sv
// Shared opcode constants, FSM state encoding and decode helper for the SPI sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
//
// Program word layout: {opcode[1:0], operand[DATA_BITS-1:0]}.
package spi_seq_pkg;

    localparam logic [1:0] OP_CMD   = 2'b00;
    localparam logic [1:0] OP_DATA  = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;
    localparam logic [1:0] OP_HALT  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_DELAY  = 3'd4
    } seqState_t;

    // CMD and DATA both move one byte over the wire; bit 0 then selects dc.
    function automatic logic isByteOp(input logic [1:0] op);
        return ~op[1];
    endfunction

endpackage

// File: rtl/seq_delay_timer.sv
// Down-counting delay timer: load a clk count, get a one-clk expire pulse on the last clk.
// Latency: expire is high during the loadVal-th clk after the load clk.
// Backpressure: none; a new load overrides a running count, reset clears it.
//
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   load, loadVal   - start a delay of loadVal clks (loadVal=0 never expires)
//   expire          - high in the final clk of the delay
module seq_delay_timer #(
    parameter int CNT_W = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Expiring on 1 rather than 0 makes the owner spend exactly loadVal clks waiting.
    assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/spi_sequencer.sv
// Program-driven SPI sequencer: fetches words, loads bytes into a shifter, inserts delays, halts.
// Latency: start -> FETCH next clk; fetch 1 clk; txLoad in the same clk as the first sclk strobe.
// Backpressure: start ignored while busy; each byte is paced by sclkPosEdge strobes.
//
// Build option: define SPI_SEQUENCER_LOOP_EN to restart the program at address 0 on HALT
// instead of returning to IDLE (busy then stays high until reset).
//
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   start        - level; starts a program run from IDLE
//   sclkPosEdge  - one-clk strobe per serial-clock rising edge
//   instr        - program word, valid the clk after memAddr is presented
//   memAddr      - program memory address
//   txLoad       - one-clk pulse loading txByte into the external shift register
//   txByte       - byte presented to the shift register
//   cs           - active-low chip select
//   dc           - 0 = command byte, 1 = data byte
//   busy         - high whenever not IDLE
//   done         - one-clk pulse when a HALT is executed
module spi_sequencer
    import spi_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_BITS  = 8,
    parameter int DELAY_TICK = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   sclkPosEdge,
    input  logic [DATA_BITS+1:0]   instr,
    output logic [ADDR_WIDTH-1:0]  memAddr,
    output logic                   txLoad,
    output logic [DATA_BITS-1:0]   txByte,
    output logic                   cs,
    output logic                   dc,
    output logic                   busy,
    output logic                   done
);

    // Counter must hold 255 * DELAY_TICK (or the wider operand equivalent) without overflow.
    localparam int OPER_W = (DATA_BITS > 8) ? DATA_BITS : 8;
    localparam int CNT_W  = OPER_W + $clog2(DELAY_TICK);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    seqState_t             state, stateNxt;
    logic [ADDR_WIDTH-1:0] memAddrNxt;
    logic [BIT_W-1:0]      bitCnt, bitCntNxt;
    logic                  csReg, csNxt;
    logic                  dcReg, dcNxt;
    logic [DATA_BITS-1:0]  txByteReg, txByteNxt;
    logic                  timerLoad;
    logic                  timerExpire;
    logic [CNT_W-1:0]      delayVal;

    logic [1:0]            opcode;
    logic [DATA_BITS-1:0]  operand;

    assign opcode   = instr[DATA_BITS+1 -: 2];
    assign operand  = instr[DATA_BITS-1:0];
    assign delayVal = CNT_W'(operand) * CNT_W'(DELAY_TICK);

    seq_delay_timer #(
        .CNT_W   (CNT_W)
    ) u_delayTimer (
        .clk     (clk),
        .reset   (reset),
        .load    (timerLoad),
        .loadVal (delayVal),
        .expire  (timerExpire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            memAddr   <= '0;
            bitCnt    <= '0;
            csReg     <= 1'b1;
            dcReg     <= 1'b0;
            txByteReg <= '0;
        end else begin
            state     <= stateNxt;
            memAddr   <= memAddrNxt;
            bitCnt    <= bitCntNxt;
            csReg     <= csNxt;
            dcReg     <= dcNxt;
            txByteReg <= txByteNxt;
        end
    end

    always_comb begin
        stateNxt   = state;
        memAddrNxt = memAddr;
        bitCntNxt  = bitCnt;
        csNxt      = csReg;
        dcNxt      = dcReg;
        txByteNxt  = txByteReg;
        timerLoad  = 1'b0;
        txLoad     = 1'b0;
        done       = 1'b0;
        cs         = csReg;
        dc         = dcReg;
        txByte     = txByteReg;
        busy       = (state != ST_IDLE);

        unique case (state)
            ST_IDLE: begin
                csNxt = 1'b1;
                if (start) begin
                    memAddrNxt = '0;
                    stateNxt   = ST_FETCH;
                end
            end

            ST_FETCH: begin
                stateNxt = ST_DECODE;
            end

            ST_DECODE: begin
                if (isByteOp(opcode)) begin
                    // Select the device and present the byte while waiting for the
                    // serial clock; dc only flips together with the load pulse.
                    cs     = 1'b0;
                    txByte = operand;
                    if (sclkPosEdge) begin
                        txLoad    = 1'b1;
                        dc        = opcode[0];
                        dcNxt     = opcode[0];
                        txByteNxt = operand;
                        csNxt     = 1'b0;
                        bitCntNxt = BIT_W'(1);
                        stateNxt  = ST_SHIFT;
                    end
                end else if (opcode == OP_DELAY) begin
                    csNxt = 1'b1;
                    if (operand == '0) begin
                        memAddrNxt = memAddr + ADDR_WIDTH'(1);
                        stateNxt   = ST_FETCH;
                    end else begin
                        timerLoad = 1'b1;
                        stateNxt  = ST_DELAY;
                    end
                end else begin
                    cs    = 1'b1;
                    csNxt = 1'b1;
                    done  = 1'b1;
`ifdef SPI_SEQUENCER_LOOP_EN
                    memAddrNxt = '0;
                    stateNxt   = ST_FETCH;
`else
                    stateNxt   = ST_IDLE;
`endif
                end
            end

            ST_SHIFT: begin
                // The load strobe already counted as bit 1.
                if (sclkPosEdge) begin
                    if (bitCnt == BIT_W'(DATA_BITS - 1)) begin
                        bitCntNxt  = '0;
                        memAddrNxt = memAddr + ADDR_WIDTH'(1);
                        stateNxt   = ST_FETCH;
                    end else begin
                        bitCntNxt = bitCnt + BIT_W'(1);
                    end
                end
            end

            ST_DELAY: begin
                if (timerExpire) begin
                    memAddrNxt = memAddr + ADDR_WIDTH'(1);
                    stateNxt   = ST_FETCH;
                end
            end

            default: begin
                stateNxt = ST_IDLE;
            end
        endcase

        // Reset wins over a strobe or HALT arriving in the same clk.
        if (reset) begin
            txLoad    = 1'b0;
            done      = 1'b0;
            timerLoad = 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_sequencer.sv
// Self-checking bench for spi_sequencer: directed programs plus randomized programs vs a program-walk model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
`timescale 1ns/1ps
module tb_spi_sequencer;
    import spi_seq_pkg::*;

    localparam int AW   = 4;
    localparam int DB   = 8;
    localparam int TICK = 10;

    logic          clk;
    logic          reset;
    logic          start;
    logic          sclkPosEdge;
    logic [DB+1:0] instr;
    logic [AW-1:0] memAddr;
    logic          txLoad;
    logic [DB-1:0] txByte;
    logic          cs;
    logic          dc;
    logic          busy;
    logic          done;

    spi_sequencer #(
        .ADDR_WIDTH (AW),
        .DATA_BITS  (DB),
        .DELAY_TICK (TICK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .sclkPosEdge (sclkPosEdge),
        .instr       (instr),
        .memAddr     (memAddr),
        .txLoad      (txLoad),
        .txByte      (txByte),
        .cs          (cs),
        .dc          (dc),
        .busy        (busy),
        .done        (done)
    );

    logic [DB+1:0] mem [16];
    int            sclkPeriod = 4;
    int            passCnt = 0;
    int            failCnt = 0;
    int            totalCnt = 0;

    // Monitor state (written only by the monitor process)
    logic [8:0]    loadLog[$];
    logic [AW-1:0] addrLog[$];
    logic [AW-1:0] lastAddr;
    int            doneCnt = 0;
    int            busyCnt = 0;
    int            csErr = 0;
    int            csLowCnt = 0;
    bit            inXfer = 1'b0;

    // Model outputs
    logic [8:0]    expLoads[$];
    int            expAddr;
    int            expBusy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read program memory: address captured at the edge, data valid just after.
    initial begin
        logic [AW-1:0] a;
        instr = '0;
        forever begin
            @(posedge clk);
            a = memAddr;
            #1 instr = mem[a];
        end
    end

    // Serial-clock rising-edge strobe every sclkPeriod clks.
    initial begin
        int ph;
        ph = 0;
        sclkPosEdge = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1 >= sclkPeriod) ? 0 : ph + 1;
            sclkPosEdge = (ph == 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        if (memAddr !== lastAddr) begin
            addrLog.push_back(memAddr);
            lastAddr = memAddr;
        end
        if (reset === 1'b1) begin
            inXfer = 1'b0;
        end else begin
            if (txLoad === 1'b1) begin
                loadLog.push_back({dc, txByte});
                inXfer = 1'b1;
            end
            if (done === 1'b1) begin
                doneCnt++;
                inXfer = 1'b0;
            end else if (inXfer && cs !== 1'b0) begin
                csErr++;
            end
            if (busy === 1'b1) busyCnt++;
            if (busy === 1'b1 && cs === 1'b0) csLowCnt++;
        end
    end

    function automatic logic [DB+1:0] mk(input logic [1:0] op, input logic [DB-1:0] v);
        return {op, v};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Walks the program from address 0 the way the sequencer is meant to execute it:
    // bytes in order, each delay costing operand*TICK clks, two clks (fetch+decode) per word.
    task automatic buildModel();
        int         a;
        int         nInstr;
        int         dly;
        logic [1:0] op;
        logic [7:0] v;
        a = 0;
        nInstr = 0;
        dly = 0;
        expLoads.delete();
        for (int k = 0; k < 64; k++) begin
            op = mem[a][9:8];
            v  = mem[a][7:0];
            nInstr++;
            if (op == OP_HALT) break;
            if (op == OP_CMD || op == OP_DATA) expLoads.push_back({op[0], v});
            if (op == OP_DELAY) dly += int'(v) * TICK;
            a = (a + 1) % 16;
        end
        expAddr = a;
        expBusy = 2 * nInstr + dly;
    endtask

    task automatic pulseStart();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int d0, input int budget);
        int n;
        n = 0;
        while (doneCnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(doneCnt == d0), 32'(0));
        @(negedge clk);
    endtask

    task automatic runProg(input string tag, input int budget);
        int d0;
        d0 = doneCnt;
        pulseStart();
        waitDone(tag, d0, budget);
    endtask

    task automatic checkLoads(input string tag, input int base);
        check({tag, "_nload"}, 32'(loadLog.size() - base), 32'(expLoads.size()));
        foreach (expLoads[i]) begin
            if (base + i < loadLog.size())
                check({tag, "_load"}, 32'(loadLog[base + i]), 32'(expLoads[i]));
        end
    endtask

    initial begin
        int lb, db, bb, ce, cl, ab, n, s, nOps, idle, bad;
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = mk(OP_HALT, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_memAddr", 32'(memAddr), 32'(0));
        check("rst_txLoad",  32'(txLoad),  32'(0));
        check("rst_txByte",  32'(txByte),  32'(0));
        check("rst_cs",      32'(cs),      32'(1));
        check("rst_dc",      32'(dc),      32'(0));
        check("rst_busy",    32'(busy),    32'(0));
        check("rst_done",    32'(done),    32'(0));
        @(posedge clk);
        #1 reset = 1'b0;

`ifdef SPI_SEQUENCER_LOOP_EN
        sclkPeriod = 4;
        mem[0] = mk(OP_CMD, 8'h10);
        mem[1] = mk(OP_HALT, 8'h00);
        buildModel();
        lb = loadLog.size();
        db = doneCnt;
        runProg("loop_first", 400);
        checkLoads("loop_first", lb);
        idle = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy !== 1'b1) idle++;
        end
        check("loop_busy_drop", 32'(idle), 32'(0));
        check("loop_passes", 32'((doneCnt - db) >= 4), 32'(1));
        n = (loadLog.size() - lb) - (doneCnt - db);
        check("loop_load_per_pass", 32'(n == 0 || n == 1), 32'(1));
        bad = 0;
        for (int i = lb; i < loadLog.size(); i++) if (loadLog[i] !== 9'h010) bad++;
        check("loop_bytes", 32'(bad), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("loop_rst_busy", 32'(busy), 32'(0));
        check("loop_rst_addr", 32'(memAddr), 32'(0));
`else
        // Two-byte command/data program with HALT
        sclkPeriod = 4;
        mem[0] = mk(OP_CMD, 8'hAE);
        mem[1] = mk(OP_DATA, 8'h55);
        mem[2] = mk(OP_HALT, 8'h00);
        buildModel();
        lb = loadLog.size(); db = doneCnt; ce = csErr;
        runProg("p1", 500);
        checkLoads("p1", lb);
        check("p1_done", 32'(doneCnt - db), 32'(1));
        check("p1_addr", 32'(memAddr), 32'(expAddr));
        check("p1_busy", 32'(busy), 32'(0));
        check("p1_cs_low", 32'(csErr - ce), 32'(0));
        check("p1_cs_idle", 32'(cs), 32'(1));

        // Delay of 3 units
        mem[0] = mk(OP_DELAY, 8'd3);
        mem[1] = mk(OP_HALT, 8'h00);
        buildModel();
        db = doneCnt; bb = busyCnt; cl = csLowCnt;
        runProg("p2", 500);
        check("p2_busy_clks", 32'(busyCnt - bb), 32'(expBusy));
        check("p2_cs_high", 32'(csLowCnt - cl), 32'(0));
        check("p2_done", 32'(doneCnt - db), 32'(1));
        check("p2_addr", 32'(memAddr), 32'(expAddr));

        // Zero delay skips DELAY entirely
        mem[0] = mk(OP_DELAY, 8'd0);
        mem[1] = mk(OP_CMD, 8'h01);
        mem[2] = mk(OP_HALT, 8'h00);
        buildModel();
        lb = loadLog.size(); db = doneCnt;
        runProg("p3", 500);
        checkLoads("p3", lb);
        check("p3_addr", 32'(memAddr), 32'(expAddr));
        mem[1] = mk(OP_DELAY, 8'd0);
        buildModel();
        bb = busyCnt;
        runProg("p3b", 200);
        check("p3b_busy_clks", 32'(busyCnt - bb), 32'(expBusy));

        // Randomized byte programs at random strobe spacing
        for (int it = 0; it < 4; it++) begin
            nOps = int'($urandom_range(1, 4));
            for (int i = 0; i < nOps; i++)
                mem[i] = mk(2'($urandom_range(0, 1)), 8'($urandom));
            mem[nOps] = mk(OP_HALT, 8'h00);
            sclkPeriod = int'($urandom_range(1, 5));
            buildModel();
            lb = loadLog.size(); db = doneCnt; ce = csErr;
            runProg("rnd_byte", 2000);
            checkLoads("rnd_byte", lb);
            check("rnd_byte_done", 32'(doneCnt - db), 32'(1));
            check("rnd_byte_addr", 32'(memAddr), 32'(expAddr));
            check("rnd_byte_cs_low", 32'(csErr - ce), 32'(0));
        end

        // Randomized delay programs
        for (int it = 0; it < 3; it++) begin
            nOps = int'($urandom_range(1, 3));
            for (int i = 0; i < nOps; i++)
                mem[i] = mk(OP_DELAY, 8'($urandom_range(0, 3)));
            mem[nOps] = mk(OP_HALT, 8'h00);
            buildModel();
            db = doneCnt; bb = busyCnt; cl = csLowCnt;
            runProg("rnd_dly", 500);
            check("rnd_dly_busy_clks", 32'(busyCnt - bb), 32'(expBusy));
            check("rnd_dly_addr", 32'(memAddr), 32'(expAddr));
            check("rnd_dly_cs_high", 32'(csLowCnt - cl), 32'(0));
        end

        // Reset in the clk of the 4th strobe of a byte
        sclkPeriod = 4;
        mem[0] = mk(OP_DELAY, 8'd0);
        mem[1] = mk(OP_CMD, 8'hA5);
        mem[2] = mk(OP_HALT, 8'h00);
        lb = loadLog.size(); db = doneCnt;
        pulseStart();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (txLoad !== 1'b1 && n < 200);
        check("mid_rst_load_seen", 32'(txLoad), 32'(1));
        s = 0;
        while (s < 3 && n < 400) begin
            @(negedge clk);
            n++;
            if (sclkPosEdge === 1'b1) s++;
        end
        check("mid_rst_addr_pre", 32'(memAddr), 32'(1));
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_cs", 32'(cs), 32'(1));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_addr", 32'(memAddr), 32'(0));
        repeat (60) @(negedge clk);
        check("mid_rst_nload", 32'(loadLog.size() - lb), 32'(1));
        check("mid_rst_no_done", 32'(doneCnt - db), 32'(0));

        // start re-asserted mid-SHIFT is ignored
        sclkPeriod = 3;
        mem[0] = mk(OP_CMD, 8'h3C);
        mem[1] = mk(OP_DATA, 8'hC3);
        mem[2] = mk(OP_HALT, 8'h00);
        buildModel();
        lb = loadLog.size(); db = doneCnt; ab = addrLog.size();
        pulseStart();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (txLoad !== 1'b1 && n < 200);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("restart", db, 500);
        checkLoads("restart", lb);
        check("restart_done", 32'(doneCnt - db), 32'(1));
        check("restart_addr", 32'(memAddr), 32'(expAddr));
        check("restart_addr_steps", 32'(addrLog.size() - ab), 32'(2));
        if (addrLog.size() - ab == 2) begin
            check("restart_addr_seq0", 32'(addrLog[ab]), 32'(1));
            check("restart_addr_seq1", 32'(addrLog[ab + 1]), 32'(2));
        end

        // Address wrap: 16 zero delays, then HALT placed at address 0 for the second visit
        for (int i = 0; i < 16; i++) mem[i] = mk(OP_DELAY, 8'd0);
        db = doneCnt; bb = busyCnt;
        pulseStart();
        n = 0;
        while (memAddr !== 4'd2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        mem[0] = mk(OP_HALT, 8'h00);
        waitDone("wrap", db, 200);
        check("wrap_done", 32'(doneCnt - db), 32'(1));
        check("wrap_addr", 32'(memAddr), 32'(0));
        check("wrap_busy_clks", 32'(busyCnt - bb), 32'(2 * (16 + 1)));
        check("wrap_idle", 32'(busy), 32'(0));
`endif

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
